// File: rtl/sd_resp_pkg.sv
// rtl/sd_resp_pkg.sv - shared state encoding and sector geometry for the SD sector responder
// Purpose: state enum, sector/word constants and the LBA-to-sector helper
// used by sd_sector_responder.
package sd_resp_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LATCH_RD = 4'd1,
    LATCH_WR = 4'd2,
    RD_FETCH = 4'd3,
    RD_LO    = 4'd4,
    RD_HI    = 4'd5,
    WR_STB   = 4'd6,
    WR_STORE = 4'd7,
    DONE     = 4'd8
  } state_e;

  localparam int SECTOR_BYTES = 512;
  localparam int WORDS        = 256;

  // SDHC cards address by sector; standard cards pass a byte address.
  function automatic logic [31:0] lba_to_sector(input logic [31:0] lba, input logic sdhc);
    return sdhc ? lba : {9'd0, lba[31:9]};
  endfunction

endpackage

// File: rtl/sd_strobe_timer.sv
// rtl/sd_strobe_timer.sv - phase down-counter generating byte strobe and sample pulses
// Purpose: one byte phase lasts STROBE_GAP+1 cycles, starting the cycle after start_i.
// Ports:
//   clk_i, reset_n_i  clock, synchronous active-low reset
//   start_i           begin a new byte phase next cycle
//   rd_strobe_o       second cycle of the phase (read data already stable one cycle)
//   wr_strobe_o       first cycle of the phase (request next write byte)
//   sample_o          DIN_LAT cycles after wr_strobe_o
//   done_o            last cycle of the phase
module sd_strobe_timer #(
  parameter int STROBE_GAP = 4,
  parameter int DIN_LAT    = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic start_i,
  output logic rd_strobe_o,
  output logic wr_strobe_o,
  output logic sample_o,
  output logic done_o
);

  localparam logic [7:0] GAP_C = 8'(STROBE_GAP);
  localparam logic [7:0] RD_C  = 8'(STROBE_GAP - 1);
  localparam logic [7:0] SMP_C = 8'(STROBE_GAP - DIN_LAT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = GAP_C;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Pulses are only meaningful while the owner sits in a timed state.
  assign wr_strobe_o = (cnt_q == GAP_C);
  assign rd_strobe_o = (cnt_q == RD_C);
  assign sample_o    = (cnt_q == SMP_C);
  assign done_o      = (cnt_q == 8'd0);

endmodule

// File: rtl/sd_sector_responder.sv
// rtl/sd_sector_responder.sv - SD sector target backed by a disk image in word-wide RAM
// Purpose: services sd_rd/sd_wr sector requests, streaming 512 bytes per sector
// between the SD byte interface and 16-bit RAM words (little-endian).
// Ports:
//   clk_ram, reset_n              clock, synchronous active-low reset
//   img_valid, img_sectors        image presence and size in sectors
//   sd_lba, sd_rd, sd_wr, sd_sdhc sector request from the initiator
//   sd_din / sd_din_strobe        write byte path
//   sd_dout / sd_dout_strobe      read byte path
//   sd_ack, sd_mounted, sd_err    transfer / mount / range status
//   mem_*                         RAM request port, held until mem_ack
module sd_sector_responder
  import sd_resp_pkg::*;
#(
  parameter logic [24:0] IMG_BASE   = 25'h0A0000,
  parameter int          STROBE_GAP = 4,
  parameter int          DIN_LAT    = 2
) (
  input  logic        clk_ram,
  input  logic        reset_n,
  input  logic        img_valid,
  input  logic [15:0] img_sectors,
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  input  logic        sd_sdhc,
  input  logic [7:0]  sd_din,
  output logic        sd_ack,
  output logic [7:0]  sd_dout,
  output logic        sd_dout_strobe,
  output logic        sd_din_strobe,
  output logic        sd_mounted,
  output logic        sd_err,
  output logic [24:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_we,
  output logic [15:0] mem_data_o,
  input  logic [15:0] mem_data_i,
  input  logic        mem_ack
);

  state_e      state_q, state_d;
  logic [24:0] base_q, base_d;
  logic [7:0]  w_q, w_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  dout_q, dout_d;
  logic        err_q, err_d;
  logic        mounted_q, mounted_d;
  logic        oor_q, oor_d;
  logic        armed_q, armed_d;
  logic        hi_q, hi_d;

  logic        tmr_start;
  logic        t_rd_stb, t_wr_stb, t_sample, t_done;
  logic [31:0] sector;
  logic        out_of_range;
  logic        last_word;

  sd_strobe_timer #(
    .STROBE_GAP (STROBE_GAP),
    .DIN_LAT    (DIN_LAT)
  ) u_timer (
    .clk_i       (clk_ram),
    .reset_n_i   (reset_n),
    .start_i     (tmr_start),
    .rd_strobe_o (t_rd_stb),
    .wr_strobe_o (t_wr_stb),
    .sample_o    (t_sample),
    .done_o      (t_done)
  );

  assign sector       = lba_to_sector(sd_lba, sd_sdhc);
  assign out_of_range = !mounted_q || (sector >= {16'd0, img_sectors});
  assign last_word    = (w_q == 8'hFF);

  // State register
  always_ff @(posedge clk_ram) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; tmr_start marks entry into a timed byte phase
  always_comb begin
    state_d   = state_q;
    tmr_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && sd_rd) begin
          state_d = LATCH_RD;
        end else if (armed_q && sd_wr) begin
          state_d = LATCH_WR;
        end
      end
      LATCH_RD: state_d = RD_FETCH;
      LATCH_WR: begin
        state_d   = WR_STB;
        tmr_start = 1'b1;
      end
      RD_FETCH: begin
        if (oor_q || mem_ack) begin
          state_d   = RD_LO;
          tmr_start = 1'b1;
        end
      end
      RD_LO: begin
        if (t_done) begin
          state_d   = RD_HI;
          tmr_start = 1'b1;
        end
      end
      RD_HI: begin
        if (t_done) begin
          state_d = last_word ? DONE : RD_FETCH;
        end
      end
      WR_STB: begin
        if (t_done) begin
          if (hi_q) begin
            state_d = WR_STORE;
          end else begin
            tmr_start = 1'b1;
          end
        end
      end
      WR_STORE: begin
        if (oor_q || mem_ack) begin
          if (last_word) begin
            state_d = DONE;
          end else begin
            state_d   = WR_STB;
            tmr_start = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    sd_ack         = 1'b0;
    mem_rd         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = 25'd0;
    mem_data_o     = 16'd0;
    sd_dout_strobe = 1'b0;
    sd_din_strobe  = 1'b0;
    sd_dout        = dout_q;
    sd_err         = err_q;
    sd_mounted     = mounted_q;
    case (state_q)
      RD_FETCH: begin
        sd_ack = 1'b1;
        mem_rd = !oor_q;
      end
      RD_LO, RD_HI: begin
        sd_ack         = 1'b1;
        sd_dout_strobe = t_rd_stb;
      end
      WR_STB: begin
        sd_ack        = 1'b1;
        sd_din_strobe = t_wr_stb;
      end
      WR_STORE: begin
        sd_ack = 1'b1;
        mem_we = !oor_q;
      end
      default: ;
    endcase
    if (mem_rd || mem_we) begin
      mem_addr = base_q + {16'd0, w_q, 1'b0};
    end
    if (mem_we) begin
      mem_data_o = word_q;
    end
  end

  // Datapath next values
  always_comb begin
    base_d    = base_q;
    w_d       = w_q;
    word_d    = word_q;
    dout_d    = dout_q;
    err_d     = err_q;
    oor_d     = oor_q;
    hi_d      = hi_q;
    mounted_d = img_valid && (img_sectors != 16'd0);
    // A low observation during DONE already counts, so a fast initiator is not locked out.
    if (!sd_rd && !sd_wr) begin
      armed_d = 1'b1;
    end else if (state_q == DONE) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
    case (state_q)
      LATCH_RD, LATCH_WR: begin
        base_d = IMG_BASE + {sector[15:0], 9'd0};
        w_d    = 8'd0;
        hi_d   = 1'b0;
        oor_d  = out_of_range;
        err_d  = out_of_range;
      end
      RD_FETCH: begin
        if (oor_q) begin
          word_d = 16'd0;
          dout_d = 8'd0;
        end else if (mem_ack) begin
          word_d = mem_data_i;
          dout_d = mem_data_i[7:0];
        end
      end
      RD_LO: begin
        if (t_done) begin
          dout_d = word_q[15:8];
        end
      end
      RD_HI: begin
        if (t_done) begin
          w_d = w_q + 8'd1;
        end
      end
      WR_STB: begin
        if (t_sample) begin
          if (hi_q) begin
            word_d[15:8] = sd_din;
          end else begin
            word_d[7:0] = sd_din;
          end
        end
        if (t_done) begin
          hi_d = !hi_q;
        end
      end
      WR_STORE: begin
        if (oor_q || mem_ack) begin
          w_d = w_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_ram) begin
    if (!reset_n) begin
      base_q    <= 25'd0;
      w_q       <= 8'd0;
      word_q    <= 16'd0;
      dout_q    <= 8'd0;
      err_q     <= 1'b0;
      oor_q     <= 1'b0;
      hi_q      <= 1'b0;
      mounted_q <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      base_q    <= base_d;
      w_q       <= w_d;
      word_q    <= word_d;
      dout_q    <= dout_d;
      err_q     <= err_d;
      oor_q     <= oor_d;
      hi_q      <= hi_d;
      mounted_q <= mounted_d;
      armed_q   <= armed_d;
    end
  end

endmodule

// File: tb/tb_sd_sector_responder.sv
// tb/tb_sd_sector_responder.sv - self-checking bench for sd_sector_responder
module tb_sd_sector_responder;

  localparam logic [24:0] IMG_BASE  = 25'h0A0000;
  localparam int          GAP       = 4;
  localparam int          IMG_WORDS = 2048;

  logic        clk_ram = 1'b0;
  logic        reset_n;
  logic        img_valid;
  logic [15:0] img_sectors;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_sdhc;
  logic [7:0]  sd_din;
  logic        sd_ack;
  logic [7:0]  sd_dout;
  logic        sd_dout_strobe, sd_din_strobe;
  logic        sd_mounted, sd_err;
  logic [24:0] mem_addr;
  logic        mem_rd, mem_we;
  logic [15:0] mem_data_o, mem_data_i;
  logic        mem_ack;

  always #5 clk_ram = ~clk_ram;

  sd_sector_responder #(
    .IMG_BASE   (IMG_BASE),
    .STROBE_GAP (GAP),
    .DIN_LAT    (2)
  ) dut (
    .clk_ram        (clk_ram),
    .reset_n        (reset_n),
    .img_valid      (img_valid),
    .img_sectors    (img_sectors),
    .sd_lba         (sd_lba),
    .sd_rd          (sd_rd),
    .sd_wr          (sd_wr),
    .sd_sdhc        (sd_sdhc),
    .sd_din         (sd_din),
    .sd_ack         (sd_ack),
    .sd_dout        (sd_dout),
    .sd_dout_strobe (sd_dout_strobe),
    .sd_din_strobe  (sd_din_strobe),
    .sd_mounted     (sd_mounted),
    .sd_err         (sd_err),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_we         (mem_we),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .mem_ack        (mem_ack)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mem_delay = 0;
  logic [15:0] ram [0:IMG_WORDS-1];

  // Model of the transfer in progress
  logic m_rd;
  logic m_oor;
  int   m_sector;
  int   n_dstb, n_istb, n_rd, n_wr, last_stb, max_gap, din_k;
  logic [7:0] cap [0:3];

  always @(posedge clk_ram) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int ram_index(input logic [24:0] a);
    int off;
    off = int'(a) - int'(IMG_BASE);
    if (off < 0 || off >= IMG_WORDS * 2) return -1;
    return off / 2;
  endfunction

  // RAM: acknowledges each request after mem_delay extra cycles
  initial begin
    int wait_n;
    int idx;
    wait_n = 0;
    mem_ack = 1'b0;
    mem_data_i = 16'd0;
    forever begin
      @(negedge clk_ram);
      if (mem_ack) begin
        mem_ack = 1'b0;
        wait_n = 0;
      end else if (mem_rd || mem_we) begin
        if (wait_n >= mem_delay) begin
          idx = ram_index(mem_addr);
          mem_ack = 1'b1;
          if (mem_rd) mem_data_i = (idx >= 0) ? ram[idx] : 16'hDEAD;
          else if (idx >= 0) ram[idx] = mem_data_o;
        end else begin
          wait_n++;
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  // Initiator write-data source: byte k of the sector is k & 0xFF
  initial begin
    sd_din = 8'd0;
    forever begin
      @(negedge clk_ram);
      if (sd_din_strobe) begin
        sd_din = 8'(din_k);
        din_k++;
      end
    end
  end

  // Compare process
  initial begin
    logic [15:0] w;
    logic [7:0]  eb;
    logic [15:0] ew;
    int idx;
    int g;
    forever begin
      @(negedge clk_ram);
      #2;
      if (sd_dout_strobe && sd_din_strobe) check("both_strobes", 1, 0);
      if ((sd_dout_strobe || sd_din_strobe || mem_rd || mem_we) && !sd_ack)
        check("ack_cover", sd_ack, 1);
      if (mem_rd && mem_we) check("rd_we_both", 1, 0);
      if (sd_dout_strobe || sd_din_strobe) begin
        if (last_stb >= 0) begin
          g = cyc - last_stb;
          if (g > max_gap) max_gap = g;
          check("strobe_gap_ok", (g > GAP) ? 1 : 0, 1);
        end
        last_stb = cyc;
      end
      if (sd_dout_strobe) begin
        if (m_oor) begin
          eb = 8'd0;
        end else begin
          idx = m_sector * 256 + n_dstb / 2;
          w = (idx < IMG_WORDS) ? ram[idx] : 16'hDEAD;
          eb = (n_dstb % 2 == 1) ? w[15:8] : w[7:0];
        end
        check("rd_byte", sd_dout, eb);
        if (n_dstb < 4) cap[n_dstb] = sd_dout;
        n_dstb++;
      end
      if (sd_din_strobe) n_istb++;
      if (mem_rd && mem_ack) begin
        check("rd_addr", mem_addr, IMG_BASE + m_sector * 512 + 2 * n_rd);
        n_rd++;
      end
      if (mem_we && mem_ack) begin
        ew[7:0]  = 8'(2 * n_wr);
        ew[15:8] = 8'(2 * n_wr + 1);
        check("wr_addr", mem_addr, IMG_BASE + m_sector * 512 + 2 * n_wr);
        check("wr_data", mem_data_o, ew);
        n_wr++;
      end
    end
  end

  task automatic begin_xfer(input logic rd, input logic wr, input logic [31:0] lba,
                            input logic sdhc, input logic hold);
    logic [31:0] sec;
    int t;
    sec = sdhc ? lba : (lba >> 9);
    m_sector = int'(sec);
    m_oor = !(img_valid && img_sectors != 16'd0) || (sec >= {16'd0, img_sectors});
    m_rd = rd;
    n_dstb = 0; n_istb = 0; n_rd = 0; n_wr = 0;
    last_stb = -1; max_gap = 0; din_k = 0;
    for (int i = 0; i < 4; i++) cap[i] = 8'hXX;
    @(negedge clk_ram);
    sd_lba = lba; sd_sdhc = sdhc; sd_rd = rd; sd_wr = wr;
    t = 0;
    while (!sd_ack && t < 20) begin
      @(negedge clk_ram);
      t++;
    end
    check("ack_rise", sd_ack, 1);
    if (!hold) begin
      sd_rd = 1'b0;
      sd_wr = 1'b0;
    end
  endtask

  task automatic end_xfer();
    int t;
    t = 0;
    while (sd_ack && t < 30000) begin
      @(negedge clk_ram);
      t++;
    end
    check("ack_fall", sd_ack, 0);
    #3;
    check("n_dout_strobes", n_dstb, m_rd ? 512 : 0);
    check("n_din_strobes", n_istb, m_rd ? 0 : 512);
    check("n_mem_acks", m_rd ? n_rd : n_wr, m_oor ? 0 : 256);
    check("err_flag", sd_err, m_oor);
  endtask

  initial begin
    int t;
    int seen;
    reset_n = 1'b0; img_valid = 1'b0; img_sectors = 16'd0;
    sd_lba = 32'd0; sd_rd = 1'b0; sd_wr = 1'b0; sd_sdhc = 1'b1;
    for (int i = 0; i < IMG_WORDS; i++) ram[i] = 16'(i * 37 + 16'h1000);
    ram[256] = 16'h1234;
    ram[257] = 16'h5678;
    repeat (3) @(negedge clk_ram);
    check("rst_ctrl", {sd_ack, sd_dout_strobe, sd_din_strobe, sd_mounted, sd_err,
                       mem_rd, mem_we, sd_dout}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_data_o, 0);
    reset_n = 1'b1;

    // Mount: sd_mounted follows img_valid && img_sectors!=0 one cycle later
    img_sectors = 16'd4;
    repeat (2) @(negedge clk_ram);
    check("mount_needs_valid", sd_mounted, 0);
    img_valid = 1'b1;
    #1;
    check("mount_not_early", sd_mounted, 0);
    @(negedge clk_ram);
    check("mount_rise", sd_mounted, 1);

    // Read sector 1, little-endian byte order
    begin_xfer(1, 0, 32'd1, 1, 0);
    end_xfer();
    check("rd1_b0", cap[0], 8'h34);
    check("rd1_b1", cap[1], 8'h12);
    check("rd1_b2", cap[2], 8'h78);
    check("rd1_b3", cap[3], 8'h56);

    // Write sector 3 with byte k = k & 0xFF, then read it back
    begin_xfer(0, 1, 32'd3, 1, 0);
    end_xfer();
    check("wr3_first_word", ram[3 * 256], 16'h0100);
    check("wr3_last_word", ram[3 * 256 + 255], 16'hFFFE);
    begin_xfer(1, 0, 32'd3, 1, 0);
    end_xfer();

    // Out of range read, then in-range read clears sd_err
    begin_xfer(1, 0, 32'd4, 1, 0);
    end_xfer();
    check("oor_err_set", sd_err, 1);
    check("oor_b0", cap[0], 8'h00);
    begin_xfer(1, 0, 32'd0, 1, 0);
    end_xfer();
    check("err_cleared", sd_err, 0);

    // Byte-addressed card (sector 2) with a slow RAM
    mem_delay = 7;
    begin_xfer(1, 0, 32'h400, 0, 0);
    end_xfer();
    check("stall_gap_stretch", (max_gap >= 7 + GAP + 1) ? 1 : 0, 1);
    mem_delay = 0;

    // Out of range write discards data
    begin_xfer(0, 1, 32'd9, 1, 0);
    end_xfer();

    // Both requests high: read wins; held levels do not retrigger
    begin_xfer(1, 1, 32'd0, 1, 1);
    end_xfer();
    seen = 0;
    repeat (40) begin
      @(negedge clk_ram);
      if (sd_ack || sd_dout_strobe || sd_din_strobe) seen++;
    end
    check("rearm_hold", seen, 0);
    sd_rd = 1'b0; sd_wr = 1'b0;
    repeat (2) @(negedge clk_ram);

    // Reset during the high byte of word 100, then restart from word 0
    begin_xfer(1, 0, 32'd1, 1, 0);
    t = 0;
    while (n_dstb < 202 && t < 5000) begin
      @(negedge clk_ram);
      t++;
    end
    check("reset_mid_active", sd_ack, 1);
    reset_n = 1'b0;
    @(negedge clk_ram);
    check("abort_ctrl", {sd_ack, sd_dout_strobe, sd_din_strobe, mem_rd, mem_we,
                         sd_mounted, sd_err, sd_dout}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_ram);
    check("remount", sd_mounted, 1);
    begin_xfer(1, 0, 32'd1, 1, 0);
    end_xfer();
    check("restart_b0", cap[0], 8'h34);
    check("restart_b1", cap[1], 8'h12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got running want finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_sector_responder.md
Name: sd_sector_responder

Overview:
- Target end of the SD sector interface: services sd_rd/sd_wr sector requests from a disk initiator.
- Backs the sectors with a disk image held in word-wide RAM.
- Streams 512 bytes out on sd_dout/sd_dout_strobe for reads.
- Collects 512 bytes on sd_din/sd_din_strobe for writes.
- Sits between a disk front end and the RAM arbiter. Replaces the host side for bench and standalone builds.

Parameters:
- IMG_BASE, 25'h0A0000: byte address of image sector 0 in RAM.
- STROBE_GAP, 4: idle cycles between consecutive data strobes (min 2).
- DIN_LAT, 2: cycles from the sd_din_strobe pulse to sampling sd_din (min 1, below STROBE_GAP).

Ports:
- clk_ram  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- img_valid  in  1  image present in RAM.
- img_sectors  in  16  image size in 512-byte sectors.
- sd_lba  in  32  sector number; byte address when sd_sdhc=0.
- sd_rd  in  1  read request, level.
- sd_wr  in  1  write request, level.
- sd_sdhc  in  1  LBA addressing mode.
- sd_din  in  8  write byte from initiator.
- sd_ack  out  1  transfer in progress.
- sd_dout  out  8  read byte.
- sd_dout_strobe  out  1  one-cycle pulse, sd_dout valid.
- sd_din_strobe  out  1  one-cycle pulse requesting the next write byte.
- sd_mounted  out  1  high while image is usable.
- sd_err  out  1  sticky, last request was out of range.
- mem_addr  out  25  RAM byte address, word-aligned.
- mem_rd  out  1  read request, held until mem_ack.
- mem_we  out  1  write request, held until mem_ack.
- mem_data_o  out  16  write word.
- mem_data_i  in  16  read word, valid in the mem_ack cycle.
- mem_ack  in  1  RAM handshake.

Behaviour:
- Reset (reset_n=0 at a clk_ram edge):
  - All outputs 0. State IDLE.
  - Any in-flight transfer is aborted: sd_ack drops, mem_rd/mem_we drop, no partial RAM write completes.
- sd_mounted:
  - Registered copy of img_valid && img_sectors!=0.
  - Rises one cycle after the condition rises.
- Sector calculation: sector = sd_sdhc ? sd_lba : sd_lba>>9.
- Range check: sector is out of range if sector >= img_sectors or !sd_mounted.
- IDLE:
  - On sd_rd=1 go to LATCH_RD; else on sd_wr=1 go to LATCH_WR. Read wins when both are high.
  - After DONE, a new request is accepted only once sd_rd and sd_wr have both been seen low for at least one cycle (re-arm rule).
- LATCH:
  - Latch sector and base = IMG_BASE + sector<<9. Clear word index w (8 bits).
  - Set sd_err = out of range. Assert sd_ack next cycle.
  - Initiator drops its request on seeing sd_ack; the responder ignores request levels until DONE.
- Read path:
  - RD_FETCH: mem_rd=1, mem_addr = base + 2*w. Hold until mem_ack, then latch the word. Out of range: skip RAM, word = 0.
  - RD_LO: sd_dout = word[7:0]; pulse sd_dout_strobe 1 cycle after sd_dout is stable for ≥1 cycle. Then STROBE_GAP idle cycles.
  - RD_HI: same for word[15:8]. Little-endian: low byte first.
  - w increments. At w wraparound 255→0 go to DONE, else RD_FETCH.
  - Exactly 512 strobes per read. sd_dout holds its value until the next byte.
- Write path:
  - WR_STB: pulse sd_din_strobe; wait DIN_LAT cycles, then sample sd_din into the low byte.
  - Wait STROBE_GAP, repeat for the high byte.
  - WR_STORE: mem_we=1, mem_data_o = word, mem_addr = base + 2*w; hold until mem_ack. Out of range: skip RAM (data discarded).
  - w increments; wrap to DONE. Exactly 512 din strobes.
- DONE: sd_ack=0 for the following cycle onward; return to IDLE.
- Stalls: mem_ack may take any number of cycles; strobes stall, they are never skipped.
- img_valid drop mid-transfer: the transfer completes unchanged; sd_mounted falls.
- sd_err clears on the next in-range request.

Decomposition:
- Package sd_resp_pkg: state enum (IDLE, LATCH_RD, LATCH_WR, RD_FETCH, RD_LO, RD_HI, WR_STB, WR_STORE, DONE), SECTOR_BYTES=512, WORDS=256.
- One natural sub-module, sd_strobe_timer: gap/latency down-counter producing the strobe and sample pulses.

Test Plan:
- Reset sweep: assert reset_n=0 during RD_HI of word 100 → sd_ack=0, mem_rd=0, all strobes 0 next cycle. A new sd_rd afterwards restarts at word 0.
- Read, image of 4 sectors, RAM words at IMG_BASE+0x200 = 0x1234,0x5678 → sd_lba=1, sd_sdhc=1 → 512 sd_dout_strobe pulses; first bytes 0x34,0x12,0x78,0x56; sd_ack high throughout, then low; sd_err=0.
- Write, sd_lba=3, initiator returns byte k&0xFF → 256 mem_we cycles; word at IMG_BASE+0x600 = 0x0100, last word 0xFFFE.
- Out of range: img_sectors=4, sd_lba=4 read → 512 strobes of 0x00, no mem_rd, sd_err=1. Next sd_lba=0 read → sd_err=0.
- Non-SDHC plus stall: sd_sdhc=0, sd_lba=0x400 → sector 2 read. mem_ack delayed 7 cycles per word → strobe spacing stretches, count stays 512.
- Simultaneous/re-arm: sd_rd=sd_wr=1 → read executes. sd_rd held high after DONE → no second transfer until it goes low; mount: img_valid rises → sd_mounted rises 1 cycle later.
